// File: rtl/regfile_pkg.sv
// project_types: shared pipeline types and constants used by the register file
package project_types;
  typedef logic reset_status_t;
  typedef logic [31:0] reg_data_t;
  typedef struct packed {
    logic en;
    logic [4:0] addr;
  } reg_info_t;
  typedef struct packed {
    logic en;
    logic [4:0] addr;
    reg_data_t data;
  } reg_t;
  localparam logic REG_ENABLE = 1'b1;
  localparam reset_status_t RST_ENABLE = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int PEND_MAX = 3;
endpackage

// File: rtl/i_regbus.sv
// i_regbus: decode-to-register-file read bus with two read ports
interface i_regbus;
  import project_types::*;
  reg_info_t r1_info, r2_info;
  reg_data_t r1_data, r2_data;
  modport master(output r1_info, r2_info, input r1_data, r2_data);
  modport slave(input r1_info, r2_info, output r1_data, r2_data);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-load counters and read stall request
module regfile_scoreboard import project_types::*; #(
  parameter int NREGS = 32,
  parameter int PEND_W = 2
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  reg_info_t     ld_issue,
  input  reg_t          wb,
  input  logic          wb_is_load,
  input  reg_info_t     r1_info,
  input  reg_info_t     r2_info,
  output logic          stall
);
  logic [PEND_W-1:0] pend [NREGS];
  logic inc, ld_wb, dec;
  assign inc = ld_issue.en && ld_issue.addr != REG_ZERO;
  assign ld_wb = wb.en == REG_ENABLE && wb_is_load && wb.addr != REG_ZERO;
  assign dec = ld_wb && pend[wb.addr] != '0;
  function automatic logic hit(reg_info_t i, logic [PEND_W-1:0] p, logic retire);
    return i.en && i.addr != REG_ZERO && p != '0 && !(p == PEND_W'(1) && retire);
  endfunction
  assign stall = rst != RST_ENABLE &&
    (hit(r1_info, pend[r1_info.addr], ld_wb && wb.addr == r1_info.addr) ||
     hit(r2_info, pend[r2_info.addr], ld_wb && wb.addr == r2_info.addr));
  always_ff @(posedge clk)
    for (int n = 0; n < NREGS; n++)
      if (rst == RST_ENABLE) pend[n] <= '0;
      else if (inc && ld_issue.addr == 5'(n) && !(dec && wb.addr == 5'(n)) && pend[n] != '1)
        pend[n] <= pend[n] + 1'b1;
      else if (dec && wb.addr == 5'(n) && !(inc && ld_issue.addr == 5'(n)))
        pend[n] <= pend[n] - 1'b1;
  assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
    !(inc && pend[ld_issue.addr] == '1 && !(dec && wb.addr == ld_issue.addr)));
  assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
    !(ld_wb && pend[wb.addr] == '0));
endmodule

// File: rtl/regfile.sv
// regfile: two-read one-write register file with write-through bypass and load stall
module regfile import project_types::*; #(
  parameter int NREGS = 32,
  parameter int PEND_W = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  reset_status_t rst,
  i_regbus.slave        read,
  input  reg_t          wb_wreg_i,
  input  logic          wb_is_load_i,
  input  reg_info_t     ld_issue_i,
  output logic          stallreq_from_regfile_o
);
  reg_data_t regs [NREGS];
  function automatic reg_data_t rd(reg_info_t i, reg_t wb, reg_data_t a);
    return (!i.en || i.addr == REG_ZERO) ? '0 :
           (wb.en == REG_ENABLE && wb.addr == i.addr) ? wb.data : a;
  endfunction
  always_ff @(posedge clk)
    if (rst == RST_ENABLE)
      for (int n = 0; n < NREGS; n++) regs[n] <= '0;
    else if (wb_wreg_i.en == REG_ENABLE && wb_wreg_i.addr != REG_ZERO)
      regs[wb_wreg_i.addr] <= wb_wreg_i.data;
  assign read.r1_data = rst == RST_ENABLE ? '0 : rd(read.r1_info, wb_wreg_i, regs[read.r1_info.addr]);
  assign read.r2_data = rst == RST_ENABLE ? '0 : rd(read.r2_info, wb_wreg_i, regs[read.r2_info.addr]);
  regfile_scoreboard #(.NREGS(NREGS), .PEND_W(PEND_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .ld_issue(ld_issue_i),
    .wb(wb_wreg_i),
    .wb_is_load(wb_is_load_i),
    .r1_info(read.r1_info),
    .r2_info(read.r2_info),
    .stall(stallreq_from_regfile_o)
  );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard-driven bench for the register file reads, bypass and load stall
module tb_regfile;
  import project_types::*;
  typedef struct packed {
    logic rst; logic r1e; logic [4:0] r1a; logic r2e; logic [4:0] r2a;
    logic we; logic [4:0] wa; logic [31:0] wd; logic isld; logic lie; logic [4:0] lia;
    logic [31:0] e1; logic [31:0] e2; logic es;
  } row_t;
  typedef struct packed {logic [31:0] e1; logic [31:0] e2; logic es;} exp_t;
  logic clk = 1'b0;
  reset_status_t rst;
  reg_t wb;
  logic is_load;
  reg_info_t ld;
  logic stall;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  i_regbus bus();
  regfile dut (
    .clk(clk),
    .rst(rst),
    .read(bus),
    .wb_wreg_i(wb),
    .wb_is_load_i(is_load),
    .ld_issue_i(ld),
    .stallreq_from_regfile_o(stall)
  );
  always #5 clk = ~clk;
  function automatic row_t mk(int rs, int r1e, int r1a, int r2e, int r2a, int we, int wa, int wd,
                              int isld, int lie, int lia, int e1, int e2, int es);
    return {1'(rs), 1'(r1e), 5'(r1a), 1'(r2e), 5'(r2a), 1'(we), 5'(wa), 32'(wd),
            1'(isld), 1'(lie), 5'(lia), 32'(e1), 32'(e2), 1'(es)};
  endfunction
  task automatic apply(input row_t r);
    rst = r.rst;
    bus.r1_info = '{r.r1e, r.r1a};
    bus.r2_info = '{r.r2e, r.r2a};
    wb = '{r.we, r.wa, r.wd};
    is_load = r.isld;
    ld = '{r.lie, r.lia};
    exp_q.push_back('{r.e1, r.e2, r.es});
  endtask
  task automatic test_reset;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1, 1, 5, 1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             mk(1, 1, 3, 1, 3, 1, 3, 'hAA, 0, 0, 0, 0, 0, 0),
             mk(0, 1, 5, 1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.r1_data, bus.r2_data, stall} !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got r1=%h r2=%h stall=%b, want r1=%h r2=%h stall=%b",
                 i, bus.r1_data, bus.r2_data, stall, e.e1, e.e2, e.es);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_bypass;
    row_t rows[$];
    exp_t e;
    rows = '{mk(0, 1, 8, 0, 8, 1, 8, 'hDEADBEEF, 0, 0, 0, 'hDEADBEEF, 0, 0),
             mk(0, 1, 8, 1, 8, 0, 0, 0, 0, 0, 0, 'hDEADBEEF, 'hDEADBEEF, 0),
             mk(0, 0, 8, 1, 8, 1, 8, 'h11, 0, 0, 0, 0, 'h11, 0),
             mk(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 'h11, 0, 0)};
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.r1_data, bus.r2_data, stall} !== e) begin
        miscompares++;
        $display("FAIL bypass[%0d]: got r1=%h r2=%h stall=%b, want r1=%h r2=%h stall=%b",
                 i, bus.r1_data, bus.r2_data, stall, e.e1, e.e2, e.es);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_zero;
    row_t rows[$];
    exp_t e;
    rows = '{mk(0, 1, 0, 1, 0, 1, 0, 'h1234, 0, 0, 0, 0, 0, 0),
             mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.r1_data, bus.r2_data, stall} !== e) begin
        miscompares++;
        $display("FAIL zero[%0d]: got r1=%h r2=%h stall=%b, want r1=%h r2=%h stall=%b",
                 i, bus.r1_data, bus.r2_data, stall, e.e1, e.e2, e.es);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_stall;
    row_t rows[$];
    exp_t e;
    rows = '{mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0),
             mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
             mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
             mk(0, 0, 9, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1),
             mk(0, 1, 9, 1, 9, 1, 9, 'h55, 1, 0, 0, 'h55, 'h55, 0),
             mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 'h55, 0, 0)};
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.r1_data, bus.r2_data, stall} !== e) begin
        miscompares++;
        $display("FAIL load_stall[%0d]: got r1=%h r2=%h stall=%b, want r1=%h r2=%h stall=%b",
                 i, bus.r1_data, bus.r2_data, stall, e.e1, e.e2, e.es);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back;
    row_t rows[$];
    exp_t e;
    rows = '{mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0),
             mk(0, 1, 4, 0, 0, 1, 4, 'h44, 1, 1, 4, 'h44, 0, 0),
             mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 'h44, 0, 1),
             mk(0, 1, 4, 0, 0, 1, 4, 'h45, 1, 0, 0, 'h45, 0, 0),
             mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 'h45, 0, 0)};
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.r1_data, bus.r2_data, stall} !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got r1=%h r2=%h stall=%b, want r1=%h r2=%h stall=%b",
                 i, bus.r1_data, bus.r2_data, stall, e.e1, e.e2, e.es);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_counts;
    row_t rows[$];
    exp_t e;
    rows = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0),
             mk(0, 1, 7, 0, 0, 1, 7, 'h77, 0, 1, 7, 'h77, 0, 1),
             mk(0, 1, 7, 0, 0, 1, 7, 'h78, 1, 0, 0, 'h78, 0, 1),
             mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 'h78, 0, 1),
             mk(0, 1, 7, 0, 0, 1, 7, 'h79, 1, 0, 0, 'h79, 0, 0),
             mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 'h79, 0, 0)};
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.r1_data, bus.r2_data, stall} !== e) begin
        miscompares++;
        $display("FAIL counts[%0d]: got r1=%h r2=%h stall=%b, want r1=%h r2=%h stall=%b",
                 i, bus.r1_data, bus.r2_data, stall, e.e1, e.e2, e.es);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid;
    row_t rows[$];
    exp_t e;
    rows = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0),
             mk(0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
             mk(1, 1, 12, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             mk(0, 1, 12, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.r1_data, bus.r2_data, stall} !== e) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got r1=%h r2=%h stall=%b, want r1=%h r2=%h stall=%b",
                 i, bus.r1_data, bus.r2_data, stall, e.e1, e.e2, e.es);
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    rst = RST_ENABLE;
    bus.r1_info = '0;
    bus.r2_info = '0;
    wb = '0;
    is_load = 1'b0;
    ld = '0;
    @(posedge clk); #1;
    test_reset;
    test_bypass;
    test_zero;
    test_load_stall;
    test_back_to_back;
    test_counts;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
